apb_master_arbiter: RTL
=======================

# apb_master_arbiter

- Sequencing APB3 master that shares one APB bus between two requesters.
- Arbitrates pending requests round-robin, runs the SETUP/ACCESS protocol and decodes the two slave selects from the address MSB.
- Returns read data and the error status to the requester that was granted.
- Sits between the test-facing master ports and the two APB slaves; it replaces direct `transfer`/`READ_WRITE` driving when more than one agent needs the bus.

## Interface
- ADDR_W, 9, request address width; MSB selects slave, lower ADDR_W-1 bits go on PADDR
- DATA_W, 8, data width
- TIMEOUT, 16, max ACCESS cycles before abort; used only with the watchdog compiled in

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  reset; synchronous, active-low
- req_valid  in  2  per-requester request; held until that requester's rsp_done
- req_write  in  2  1 = write, 0 = read; held stable while req_valid
- req_addr  in  2*ADDR_W  per-requester address; requester i uses slice i
- req_wdata  in  2*DATA_W  per-requester write data
- rsp_done  out  2  one-cycle completion pulse to the granted requester
- rsp_rdata  out  DATA_W  read data; valid while rsp_done is nonzero
- rsp_err  out  1  PSLVERR or timeout status; valid while rsp_done is nonzero
- PSEL1  out  1  slave 1 select (addr MSB = 0)
- PSEL2  out  1  slave 2 select (addr MSB = 1)
- PENABLE  out  1  APB access phase
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W-1  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error

## Operation
States:
- IDLE: no select asserted.
  - On any req_valid, grant one requester and latch its write/addr/wdata.
  - Go to SETUP.
- SETUP: selected PSELx=1, PENABLE=0. Always go to ACCESS.
- ACCESS: PSELx=1, PENABLE=1.
  - PREADY=1 sampled: latch PRDATA (reads only; 0 on writes) and PSLVERR, go to IDLE.
  - Otherwise stay in ACCESS.

Arbitration:
- Pointer last_gnt resets to 1, so requester 0 wins the first tie.
- Both valid: grant the requester != last_gnt. Only one valid: grant it.
- last_gnt updates at grant.

Bus signals:
- PADDR, PWRITE and PWDATA come from registered latches and stay stable from SETUP through ACCESS.
- Outside a transfer they hold their last values.

Completion:
- rsp_done[g] is registered and is high in the first IDLE cycle after ACCESS completes.
- rsp_rdata and rsp_err are valid in that same cycle.
- In a cycle where rsp_done[i]=1, req_valid[i] is ignored. This prevents re-issuing a stale request.
- The other requester may be granted in that same cycle.

Reset:
- All outputs 0, state IDLE, last_gnt=1, latches 0.
- Reset mid-transfer: PSELx/PENABLE drop at the next edge and no rsp_done is produced.

## Timing
- Request first sampled at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2.
- With PREADY=1 in cycle 2, rsp_done is high in cycle 3. Minimum latency is 3 cycles.
- Each PREADY=0 cycle in ACCESS adds one cycle.
- Back-to-back requests: the next SETUP at the earliest 1 cycle after rsp_done (cycle 4). Bus throughput is 1 transfer per 3 cycles.
- PENABLE is never high without a PSELx, and never high in the first cycle of a transfer.
- PSEL1 and PSEL2 are never both high.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - A counter runs in ACCESS.
  - After TIMEOUT consecutive ACCESS cycles with PREADY=0, the transfer aborts:
    - PSELx/PENABLE drop at the next edge and the state goes to IDLE.
    - rsp_done pulses with rsp_err=1 and rsp_rdata=0.
  - PREADY arriving in cycle TIMEOUT completes the transfer normally.
- Not defined: no counter; ACCESS waits indefinitely for PREADY.

## Structure
- Package apb_arb_pkg:
  - state typedef (IDLE, SETUP, ACCESS);
  - default ADDR_W, DATA_W and TIMEOUT constants.
- Sub-module apb_rr_arb: 2-way round-robin grant logic.
  - Inputs: req, enable (IDLE), the mask of the just-completed requester.
  - Outputs: one-hot grant; owns the last_gnt register.

## Test plan
- Requester 0 writes addr 0x005, data 0xA5, PREADY=1:
  - PSEL1, PADDR=0x05, PWRITE=1, PWDATA=0xA5;
  - PENABLE rises in the 2nd cycle;
  - rsp_done=2'b01 in cycle 3, rsp_err=0.
- Requester 1 reads addr 0x10C, PREADY low 3 cycles, PRDATA=0x3C, PSLVERR=1:
  - PSEL2, PADDR=0x0C;
  - rsp_done=2'b10 in cycle 6 with rsp_rdata=0x3C, rsp_err=1.
- Both requesters valid continuously from reset:
  - grants alternate 0,1,0,1;
  - no cycle with both PSELs high;
  - SETUP follows each rsp_done by exactly 1 cycle.
- Assert PRESETn=0 during ACCESS:
  - all outputs 0 at the next edge, no rsp_done;
  - after release, requester 0 wins a tie.
- With APB_ARB_TIMEOUT_EN and TIMEOUT=16, PREADY held low:
  - abort after 16 ACCESS cycles;
  - rsp_err=1, rsp_rdata=0x00;
  - a following request completes normally.

Source files
------------

// File: rtl/apb_master_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_pkg
// Description : Shared types and default sizes for the two-requester APB
//               master/arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

   localparam int DEF_ADDR_W  = 9;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_TIMEOUT = 16;

   // APB transfer phases
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/apb_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_arbiter_if
// Description : Requester-side and APB-side signal bundle of the arbiter.
//               The master modport is the arbiter's view; the slave modport is
//               the view of the agents and APB slaves around it.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_arbiter_if
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   // requester side
   logic [1:0]          req_valid;
   logic [1:0]          req_write;
   logic [2*ADDR_W-1:0] req_addr;
   logic [2*DATA_W-1:0] req_wdata;
   logic [1:0]          rsp_done;
   logic [DATA_W-1:0]   rsp_rdata;
   logic                rsp_err;

   // APB side
   logic                PSEL1;
   logic                PSEL2;
   logic                PENABLE;
   logic                PWRITE;
   logic [ADDR_W-2:0]   PADDR;
   logic [DATA_W-1:0]   PWDATA;
   logic [DATA_W-1:0]   PRDATA;
   logic                PREADY;
   logic                PSLVERR;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output rsp_done, rsp_rdata, rsp_err,
      output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  rsp_done, rsp_rdata, rsp_err,
      input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface
`default_nettype wire

// File: rtl/apb_master_arbiter_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_arb
// Description : Two-way round-robin grant. A requester that is completing in
//               this cycle is masked so its stale request cannot win again.
//               Owns the last-grant pointer, which resets to requester 1 so
//               requester 0 wins the first tie.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_arb
   import apb_arb_pkg::*;
(
   input  wire logic       PCLK,
   input  wire logic       PRESETn,
   input  wire logic [1:0] req,
   input  wire logic       enable,
   input  wire logic [1:0] done_mask,
   output logic      [1:0] gnt
);

   logic       last_gnt;
   logic [1:0] eligible;

   // pick a one-hot winner among eligible requesters, favouring the one not served last
   always_comb begin
      eligible = req & ~done_mask;
      gnt      = 2'b00;
      if (enable) begin
         case (eligible)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // remember who was granted most recently
   always_ff @(posedge PCLK) begin
      if (!PRESETn)
         last_gnt <= 1'b1;
      else if (gnt != 2'b00)
         last_gnt <= gnt[1];
   end

endmodule
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_arbiter
// Description : APB3 master shared by two requesters. Round-robin grant,
//               SETUP/ACCESS sequencing, slave select from the address MSB,
//               and a registered one-cycle completion pulse carrying read
//               data and error status back to the granted requester.
//               Optional ACCESS watchdog enabled by APB_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
)(
   input  wire logic            PCLK,
   input  wire logic            PRESETn,
   apb_master_arbiter_if.master bus
);

   state_t              state;
   state_t              state_nxt;
   logic [1:0]          gnt;
   logic                psel;
   logic                penable;
   logic                finish;
   logic                abort;

   logic [ADDR_W-1:0]   sel_addr;
   logic                sel_write;
   logic [DATA_W-1:0]   sel_wdata;

   logic                owner;
   logic                slave_hi;
   logic                write_lat;
   logic [ADDR_W-2:0]   addr_lat;
   logic [DATA_W-1:0]   wdata_lat;
   logic [1:0]          done_pulse;
   logic [DATA_W-1:0]   rdata_lat;
   logic                err_lat;

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("TIMEOUT must be at least 1");
   end

   apb_rr_arb u_arb (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .req       (bus.req_valid),
      .enable    (state == IDLE),
      .done_mask (done_pulse),
      .gnt       (gnt)
   );

   // request fields of whichever requester is being granted
   assign sel_addr  = gnt[1] ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
   assign sel_wdata = gnt[1] ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
   assign sel_write = gnt[1] ? bus.req_write[1]                 : bus.req_write[0];

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] wd_cnt;

   // count elapsed ACCESS cycles of the current transfer
   always_ff @(posedge PCLK) begin
      if (!PRESETn || state != ACCESS)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + 1'b1;
   end
`endif

   // phase register
   always_ff @(posedge PCLK) begin
      if (!PRESETn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next phase and APB strobes
   always_comb begin
      state_nxt = state;
      psel      = 1'b0;
      penable   = 1'b0;
      finish    = 1'b0;
      abort     = 1'b0;
      case (state)
         IDLE: begin
            if (gnt != 2'b00)
               state_nxt = SETUP;
         end
         SETUP: begin
            psel      = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (bus.PREADY) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   // capture the granted request; held unchanged until the next grant
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         owner     <= 1'b0;
         slave_hi  <= 1'b0;
         write_lat <= 1'b0;
         addr_lat  <= '0;
         wdata_lat <= '0;
      end else if (gnt != 2'b00) begin
         owner     <= gnt[1];
         slave_hi  <= sel_addr[ADDR_W-1];
         write_lat <= sel_write;
         addr_lat  <= sel_addr[ADDR_W-2:0];
         wdata_lat <= sel_wdata;
      end
   end

   // completion pulse with read data and status for the owner
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         done_pulse <= 2'b00;
         rdata_lat  <= '0;
         err_lat    <= 1'b0;
      end else begin
         done_pulse <= 2'b00;
         if (finish) begin
            done_pulse <= {owner, ~owner};
            rdata_lat  <= write_lat ? '0 : bus.PRDATA;
            err_lat    <= bus.PSLVERR;
         end else if (abort) begin
            done_pulse <= {owner, ~owner};
            rdata_lat  <= '0;
            err_lat    <= 1'b1;
         end
      end
   end

   assign bus.PSEL1     = psel & ~slave_hi;
   assign bus.PSEL2     = psel &  slave_hi;
   assign bus.PENABLE   = penable;
   assign bus.PWRITE    = write_lat;
   assign bus.PADDR     = addr_lat;
   assign bus.PWDATA    = wdata_lat;
   assign bus.rsp_done  = done_pulse;
   assign bus.rsp_rdata = rdata_lat;
   assign bus.rsp_err   = err_lat;

endmodule
`default_nettype wire
